// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU package: pipeline action encoding and event counter defaults.
// The datapath and the debug readout use the same State encoding.
package hazard_stall_ctrl_pkg;

    // Default width of the saturating event counters
    localparam int CNT_W_DEFAULT = 16;

    // Default limit on consecutive freeze cycles before the timeout flag sets
    localparam int MAX_FREEZE_DEFAULT = 255;

    // One pipeline action is chosen per cycle; the encoding is visible on State
    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } action_e;

    // Load-use hazard: the EX load writes a register that the ID instruction reads.
    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic calc_load_use(
        input logic       mem_read,
        input logic [4:0] target,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       rt_used
    );
        return mem_read && (target != 5'd0) &&
               ((target == rs) || (rt_used && (target == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter: counts up by one per enabled edge, holds at all-ones.
import hazard_stall_ctrl_pkg::*;

module sat_counter #(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: increment when requested unless already at the ceiling
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for a five-stage pipeline. Picks one action per
// cycle (freeze > flush > stall > run), drives the pipeline enables
// combinationally, and keeps event statistics plus a memory-timeout flag.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int MAX_FREEZE = MAX_FREEZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             RtUsed_IF_ID,
    input  logic [4:0]       RegTarget_ID_EX,
    input  logic             MemRead_ID_EX,
    input  logic             Branch_Taken_Ex_Mem,
    input  logic             Mem_Busy,
    output logic             PC_Wr,
    output logic             IF_ID_Wr,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Ex_Mem_Flush,
    output logic             Pipe_Freeze,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Freeze_Cnt,
    output logic             Mem_Timeout
);

    // Width of the consecutive-freeze counter, large enough to hold MAX_FREEZE
    localparam int FW = (MAX_FREEZE > 1) ? $clog2(MAX_FREEZE + 1) : 1;
    localparam logic [FW-1:0] FREEZE_LIMIT = FW'(MAX_FREEZE);

    logic          load_use;
    action_e       action;
    action_e       state_q;
    action_e       state_d;
    logic [FW-1:0] freeze_run_q;
    logic [FW-1:0] freeze_run_d;
    logic          timeout_q;
    logic          timeout_d;

    assign load_use = calc_load_use(MemRead_ID_EX, RegTarget_ID_EX,
                                    Rs_IF_ID, Rt_IF_ID, RtUsed_IF_ID);

    // Action select; a taken branch outranks a load-use because it discards the dependent instruction
    always_comb begin
        action = ACT_RUN;
        if (Mem_Busy) begin
            action = ACT_FREEZE;
        end else if (Branch_Taken_Ex_Mem) begin
            action = ACT_FLUSH;
        end else if (load_use) begin
            action = ACT_STALL;
        end
    end

    // Pipeline controls decoded from the action; reset parks the pipe with a bubble and no writes
    always_comb begin
        PC_Wr        = 1'b0;
        IF_ID_Wr     = 1'b0;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Ex_Mem_Flush = 1'b0;
        Pipe_Freeze  = 1'b0;
        if (!rst_n) begin
            ID_EX_Bubble = 1'b1;
        end else begin
            case (action)
                ACT_RUN: begin
                    PC_Wr    = 1'b1;
                    IF_ID_Wr = 1'b1;
                end
                ACT_STALL: begin
                    ID_EX_Bubble = 1'b1;
                end
                ACT_FLUSH: begin
                    PC_Wr        = 1'b1;
                    IF_ID_Wr     = 1'b1;
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Flush  = 1'b1;
                    Ex_Mem_Flush = 1'b1;
                end
                ACT_FREEZE: begin
                    Pipe_Freeze = 1'b1;
                end
                default: begin
                    PC_Wr    = 1'b0;
                    IF_ID_Wr = 1'b0;
                end
            endcase
        end
    end

    // Next state for the action register, freeze run length and sticky timeout
    always_comb begin
        state_d      = action;
        freeze_run_d = '0;
        timeout_d    = timeout_q;
        if (action == ACT_FREEZE) begin
            freeze_run_d = freeze_run_q;
            if (freeze_run_q != FREEZE_LIMIT) begin
                freeze_run_d = freeze_run_q + FW'(1);
            end
            if (freeze_run_d == FREEZE_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Action, freeze-run and timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACT_RUN;
            freeze_run_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            freeze_run_q <= freeze_run_d;
            timeout_q    <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (action == ACT_STALL),
        .count (Stall_Cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (action == ACT_FLUSH),
        .count (Flush_Cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (action == ACT_FREEZE),
        .count (Freeze_Cnt)
    );

    assign State       = state_q;
    assign Mem_Timeout = timeout_q;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating event counters.
REQ-002 SHALL have parameter MAX_FREEZE, default 255, limit on consecutive freeze cycles before the timeout flag sets.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: Rs_IF_ID  in  5  and  Rt_IF_ID  in  5  — source register numbers of the instruction in ID.
REQ-006 SHALL have ports: RtUsed_IF_ID  in  1  — the ID instruction reads Rt as a register operand, not as a store/immediate target.
REQ-007 SHALL have ports: RegTarget_ID_EX  in  5  and  MemRead_ID_EX  in  1  — destination and load flag of the instruction in EX.
REQ-008 SHALL have ports: Branch_Taken_Ex_Mem  in  1  — a branch or jump resolved taken in MEM.
REQ-009 SHALL have ports: Mem_Busy  in  1  — data memory wait request.
REQ-010 SHALL have ports: PC_Wr  out  1,  IF_ID_Wr  out  1,  ID_EX_Bubble  out  1  — the pipeline-register enables and the bubble control.
REQ-011 SHALL have ports: IF_ID_Flush, ID_EX_Flush, Ex_Mem_Flush  out  1 each  — clear the pipeline register at the next edge.
REQ-012 SHALL have ports: Pipe_Freeze  out  1  — hold every pipeline register.
REQ-013 SHALL have ports: State  out  2,  Stall_Cnt, Flush_Cnt, Freeze_Cnt  out  CNT_W,  Mem_Timeout  out  1.

Function
REQ-014 SHALL compute load_use = MemRead_ID_EX & (RegTarget_ID_EX != 0) & (RegTarget_ID_EX == Rs_IF_ID | (RtUsed_IF_ID & RegTarget_ID_EX == Rt_IF_ID)).
REQ-015 SHALL select one action per cycle combinationally, in priority order: FREEZE if Mem_Busy, else FLUSH if Branch_Taken_Ex_Mem, else STALL if load_use, else RUN.
REQ-016 SHALL drive the RUN outputs as: PC_Wr=1, IF_ID_Wr=1, all other controls 0.
REQ-017 SHALL drive the STALL outputs as: PC_Wr=0, IF_ID_Wr=0, ID_EX_Bubble=1, no flushes.
REQ-018 SHALL drive the FLUSH outputs as: PC_Wr=1, IF_ID_Flush=ID_EX_Flush=Ex_Mem_Flush=1, IF_ID_Wr=1, ID_EX_Bubble=0.
REQ-019 SHALL drive the FREEZE outputs as: Pipe_Freeze=1, PC_Wr=0, IF_ID_Wr=0, no bubble, no flushes.
REQ-020 SHALL make these control outputs combinational (zero latency); they take effect at the next rising edge.
REQ-021 SHALL register the selected action into State each edge, encoded RUN=0, STALL=1, FLUSH=2, FREEZE=3.
REQ-022 SHALL increment Stall_Cnt, Flush_Cnt or Freeze_Cnt by one on each edge whose selected action is STALL, FLUSH or FREEZE respectively.
REQ-023 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-024 SHALL keep an internal consecutive-freeze counter: +1 per FREEZE edge, cleared on any non-FREEZE edge, saturating at MAX_FREEZE.
REQ-025 SHALL set Mem_Timeout at the edge where the consecutive-freeze count reaches MAX_FREEZE; it is sticky until reset.
REQ-026 SHALL, when a branch flush and a load-use occur together, take FLUSH with no stall counted, since the dependent instruction is discarded.
REQ-027 SHALL, when Mem_Busy coincides with a branch, take FREEZE; the flush is taken on the first cycle after Mem_Busy falls, provided Branch_Taken_Ex_Mem is still held.
REQ-028 SHALL treat register 0 as never hazardous.

Reset
REQ-029 SHALL, while rst_n=0: State=RUN, all counters 0, Mem_Timeout=0, freeze counter 0.
REQ-030 SHALL, while rst_n=0: PC_Wr=0, IF_ID_Wr=0, ID_EX_Bubble=1, flushes 0, Pipe_Freeze=0.
REQ-031 SHALL, on deassertion mid-operation, have the first post-reset edge behave per REQ-015 with zeroed history.

Structure
REQ-032 SHALL place the State encoding constants and the CNT_W default in the shared CPU package, also used by the datapath and the debug readout.
REQ-033 SHALL be one module with one natural sub-module, sat_counter, instantiated three times for the event counters.

Verification
REQ-034 SHALL cover: lw writes $8 in EX, add reads Rs=$8 in ID -> PC_Wr=0, IF_ID_Wr=0, ID_EX_Bubble=1; next cycle State=1, Stall_Cnt=1.
REQ-035 SHALL cover: MemRead_ID_EX=1 with RegTarget=0 and Rs=0 -> RUN, no stall.
REQ-036 SHALL cover: Branch_Taken_Ex_Mem=1 together with load_use -> all three flushes=1, PC_Wr=1; Flush_Cnt=1, Stall_Cnt=0.
REQ-037 SHALL cover: Mem_Busy high 255 cycles -> Pipe_Freeze=1 throughout, Mem_Timeout=1 after the 255th edge, staying 1 after Mem_Busy falls.
REQ-038 SHALL cover: CNT_W=4, 20 consecutive stalls -> Stall_Cnt holds at 15.
REQ-039 SHALL cover: rst_n asserted during FREEZE -> State=0, counters 0 immediately, without waiting for a clock edge.
